// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the serial-config bus arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_e;

  // Watchdog/gap counter width: enough for the longest timeout plus one headroom bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return 32'($clog2(m)) + 32'd1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic [1:0]      o_gnt_idx,
  output logic            o_gnt_vld
);

  localparam int unsigned IW = idx_width(NREQ);

  // Scan farthest-first so the nearest requester after the pointer wins.
  always_comb begin
    int idx;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    idx       = 0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      idx = (int'(i_ptr) + k) % int'(NREQ);
      if (i_req[IW'(idx)]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one serial-config shifter between NREQ sequencers: word-granular
// round-robin with burst lock, CSB idle gap, and a shifter watchdog.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned ACK_TO  = 16,
  parameter int unsigned DONE_TO = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    req_err,
  output logic               shf_start,
  output logic [DW-1:0]      shf_data,
  input  logic               shf_busy,
  output logic [1:0]         grant_id,
  output logic               arb_busy,
  output logic               timeout_err
);

  localparam int unsigned CW = cnt_width(ACK_TO, DONE_TO, GAP_CYC);
  localparam int unsigned IW = idx_width(NREQ);

  arb_state_e      r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n, w_cnt_inc;
  logic [1:0]      r_ptr, w_ptr_n, r_gid, w_gid_n, w_g;
  logic            r_lock, w_lock_n, w_lock_hit;
  logic [DW-1:0]   r_data, w_data_n;
  logic            r_start, w_start_n;
  logic [NREQ-1:0] r_ack, w_ack_n, r_done, w_done_n, r_err, w_err_n, w_onehot;
  logic            r_terr, w_terr_n, r_arb_busy, w_arb_busy_n;
  logic [1:0]      w_pick_idx;
  logic            w_pick_vld;

  spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_pick_idx),
    .o_gnt_vld (w_pick_vld)
  );

  assign w_lock_hit = r_lock & req_valid[IW'(r_gid)];
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  assign w_onehot   = NREQ'(1) << r_gid;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_cnt_inc;
    w_ptr_n   = r_ptr;
    w_gid_n   = r_gid;
    w_lock_n  = r_lock;
    w_data_n  = r_data;
    w_start_n = 1'b0;
    w_ack_n   = '0;
    w_done_n  = '0;
    w_err_n   = '0;
    w_terr_n  = r_terr;
    w_g       = w_lock_hit ? r_gid : w_pick_idx;

    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (r_lock && !req_valid[IW'(r_gid)]) w_lock_n = 1'b0;
        // Foreign shifter activity blocks any new grant.
        if (!shf_busy && (w_lock_hit || w_pick_vld)) begin
          w_state_n = LAUNCH;
          w_gid_n   = w_g;
          w_ptr_n   = w_g;
          w_lock_n  = req_lock[IW'(w_g)];
          w_data_n  = req_data[32'(w_g) * DW +: DW];
          w_start_n = 1'b1;
          w_ack_n   = NREQ'(1) << w_g;
        end
      end
      LAUNCH: w_state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (shf_busy) begin
          w_state_n = WAIT_DONE;
          w_cnt_n   = CW'(1);
        end else if (r_cnt >= CW'(ACK_TO - 1)) begin
          w_state_n = GAP;
          w_cnt_n   = '0;
          w_err_n   = w_onehot;
          w_terr_n  = 1'b1;
          w_lock_n  = 1'b0;
        end
      end
      WAIT_DONE: begin
        // Only entered with busy high, so low here is the falling edge.
        if (!shf_busy) begin
          w_state_n = GAP;
          w_cnt_n   = '0;
          w_done_n  = w_onehot;
        end else if (r_cnt >= CW'(DONE_TO - 1)) begin
          w_state_n = GAP;
          w_cnt_n   = '0;
          w_err_n   = w_onehot;
          w_terr_n  = 1'b1;
          w_lock_n  = 1'b0;
        end
      end
      GAP: begin
        if (r_cnt >= CW'(GAP_CYC - 1)) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase

    w_arb_busy_n = (w_state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= 2'(NREQ - 1);
      r_gid      <= '0;
      r_lock     <= 1'b0;
      r_data     <= '0;
      r_start    <= 1'b0;
      r_ack      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_terr     <= 1'b0;
      r_arb_busy <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_ptr      <= w_ptr_n;
      r_gid      <= w_gid_n;
      r_lock     <= w_lock_n;
      r_data     <= w_data_n;
      r_start    <= w_start_n;
      r_ack      <= w_ack_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
      r_terr     <= w_terr_n;
      r_arb_busy <= w_arb_busy_n;
    end
  end

  assign req_ack     = r_ack;
  assign req_done    = r_done;
  assign req_err     = r_err;
  assign shf_start   = r_start;
  assign shf_data    = r_data;
  assign grant_id    = r_gid;
  assign arb_busy    = r_arb_busy;
  assign timeout_err = r_terr;

endmodule
